pwm_deadtime: RTL and testbench

Complementary-output stage placed directly downstream of the PWM core. It takes the single modulated PWM waveform and drives a high-side/low-side gate-drive pair with programmable dead time inserted at every transition. The two sides are never active together. Pulses shorter than the dead time are swallowed. It runs on the same clock as the PWM core, and its outputs go to the pads.

---
 rtl/pwm_deadtime.sv | 191 +++++++++++++++++++
 tb/tb_pwm_deadtime.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime.sv
// pwm_deadtime
//   Complementary gate-drive stage. Takes one modulated PWM waveform and drives
//   a high-side/low-side pair with programmable dead time before each side turns
//   on. The two sides are never on together. A pulse shorter than the dead time
//   is swallowed, and the side that was on before the pulse is restored.
//
// Build option:
//   PWM_DT_DROP_CNT_EN  when defined, o_drop_cnt counts swallowed pulses. The
//                       count saturates at 255 and clears only on rst. When not
//                       defined, o_drop_cnt is tied to 0.
//
// Parameters:
//   DT_W       dead-time counter width (max dead time 2^DT_W-1 cycles)
//   H_ACT_LOW  o_pwm_h is active-low at the pin when 1
//   L_ACT_LOW  o_pwm_l is active-low at the pin when 1
//
// Ports:
//   clk          PWM core clock
//   rst          asynchronous, active-high reset
//   en           stage enable; when low, both sides are inactive
//   i_pwm        modulated PWM, synchronous to clk
//   dt_hi        dead cycles before the high side turns on
//   dt_lo        dead cycles before the low side turns on
//   o_pwm_h      high-side drive (registered, polarity per H_ACT_LOW)
//   o_pwm_l      low-side drive (registered, polarity per L_ACT_LOW)
//   o_dt_active  high while in a dead-time state
//   o_drop_cnt   saturating count of swallowed pulses
module pwm_deadtime #(
  parameter int unsigned DT_W      = 8,
  parameter bit          H_ACT_LOW = 1'b0,
  parameter bit          L_ACT_LOW = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            i_pwm,
  input  logic [DT_W-1:0] dt_hi,
  input  logic [DT_W-1:0] dt_lo,
  output logic            o_pwm_h,
  output logic            o_pwm_l,
  output logic            o_dt_active,
  output logic [7:0]      o_drop_cnt
);

  typedef enum logic [2:0] {
    OFF,
    DT_H,
    ON_H,
    DT_L,
    ON_L
  } state_t;

  state_t          state_q, state_d;
  logic            h_q, h_d;
  logic            l_q, l_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic            dt_active_q, dt_active_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= OFF;
      h_q         <= 1'b0;
      l_q         <= 1'b0;
      cnt_q       <= '0;
      dt_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      l_q         <= l_d;
      cnt_q       <= cnt_d;
      dt_active_q <= dt_active_d;
    end
  end

  // The outgoing side is dropped at the same edge the new PWM level is
  // sampled; the incoming side rises dt edges later, giving exactly dt
  // both-off cycles. The dead time is captured into cnt on DT_x entry only.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    l_d     = l_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = OFF;
      h_d     = 1'b0;
      l_d     = 1'b0;
    end else begin
      unique case (state_q)
        OFF: begin
          if (i_pwm) begin
            if (dt_hi == '0) begin
              state_d = ON_H;
              h_d     = 1'b1;
            end else begin
              state_d = DT_H;
              cnt_d   = dt_hi - DT_W'(1);
            end
          end else begin
            if (dt_lo == '0) begin
              state_d = ON_L;
              l_d     = 1'b1;
            end else begin
              state_d = DT_L;
              cnt_d   = dt_lo - DT_W'(1);
            end
          end
        end
        ON_L: begin
          if (i_pwm) begin
            l_d = 1'b0;
            if (dt_hi == '0) begin
              state_d = ON_H;
              h_d     = 1'b1;
            end else begin
              state_d = DT_H;
              cnt_d   = dt_hi - DT_W'(1);
            end
          end
        end
        ON_H: begin
          if (!i_pwm) begin
            h_d = 1'b0;
            if (dt_lo == '0) begin
              state_d = ON_L;
              l_d     = 1'b1;
            end else begin
              state_d = DT_L;
              cnt_d   = dt_lo - DT_W'(1);
            end
          end
        end
        DT_H: begin
          // Input fell back before the window expired: restore the low side.
          if (!i_pwm) begin
            state_d = ON_L;
            l_d     = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = ON_H;
            h_d     = 1'b1;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        DT_L: begin
          if (i_pwm) begin
            state_d = ON_H;
            h_d     = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = ON_L;
            l_d     = 1'b1;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        default: begin
          state_d = OFF;
          h_d     = 1'b0;
          l_d     = 1'b0;
        end
      endcase
    end
    dt_active_d = (state_d == DT_H) || (state_d == DT_L);
  end

  assign o_pwm_h     = h_q ^ H_ACT_LOW;
  assign o_pwm_l     = l_q ^ L_ACT_LOW;
  assign o_dt_active = dt_active_q;

`ifdef PWM_DT_DROP_CNT_EN
  logic       drop_evt;
  logic [7:0] drop_q;

  // A swallow is exactly an en=1 edge in DT_x with the input back at the
  // side that was on before the window started.
  assign drop_evt = en && (((state_q == DT_H) && !i_pwm) ||
                           ((state_q == DT_L) &&  i_pwm));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else if (drop_evt && (drop_q != '1)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign o_drop_cnt = drop_q;
`else
  assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pwm_deadtime.sv
// tb_pwm_deadtime
//   Scoreboard bench for pwm_deadtime. Two instances share the stimulus: one
//   with active-high pins, one with both pins active-low. The reference model
//   tracks which side owns the drive and, while a handover is pending, the
//   absolute edge number at which the incoming side is due to turn on.
module tb_pwm_deadtime;

  logic       clk;
  logic       rst;
  logic       en;
  logic       i_pwm;
  logic [7:0] dt_hi;
  logic [7:0] dt_lo;

  logic       ah, al, adt;
  logic [7:0] adrop;
  logic       bh, bl, bdt;
  logic [7:0] bdrop;

  pwm_deadtime #(.DT_W(8), .H_ACT_LOW(1'b0), .L_ACT_LOW(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .i_pwm(i_pwm), .dt_hi(dt_hi), .dt_lo(dt_lo),
    .o_pwm_h(ah), .o_pwm_l(al), .o_dt_active(adt), .o_drop_cnt(adrop)
  );

  pwm_deadtime #(.DT_W(8), .H_ACT_LOW(1'b1), .L_ACT_LOW(1'b1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .i_pwm(i_pwm), .dt_hi(dt_hi), .dt_lo(dt_lo),
    .o_pwm_h(bh), .o_pwm_l(bl), .o_dt_active(bdt), .o_drop_cnt(bdrop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       h;
    logic       l;
    logic       dta;
    logic [7:0] drop;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned n_checks;
  int unsigned n_fail;

  // Reference model: owner 0=none, 1=high, 2=low; pend = side waiting to
  // turn on (0 = none) at absolute edge number due.
  int          owner;
  int          pend;
  longint      edge_n;
  longint      due;
  int          drop;

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got h,l,dt,drop=%b required %b", name, $time, act, req);
    end
  endtask

  task automatic model_reset();
    owner = 0;
    pend  = 0;
    drop  = 0;
  endtask

  task automatic model_edge(input logic e, input logic p, input logic [7:0] dh, input logic [7:0] dl);
    int want;
    int d;
    exp_t x;
    edge_n++;
    want = p ? 1 : 2;
    if (!e) begin
      owner = 0;
      pend  = 0;
    end else if (pend != 0) begin
      if (want != pend) begin
        owner = want;
        pend  = 0;
`ifdef PWM_DT_DROP_CNT_EN
        if (drop < 255) drop++;
`endif
      end else if (edge_n == due) begin
        owner = pend;
        pend  = 0;
      end
    end else if (owner != want) begin
      d = (want == 1) ? int'(dh) : int'(dl);
      if (d == 0) begin
        owner = want;
      end else begin
        owner = 0;
        pend  = want;
        due   = edge_n + longint'(d);
      end
    end
    x.h    = (owner == 1);
    x.l    = (owner == 2);
    x.dta  = (pend != 0);
    x.drop = 8'(drop);
    sb.push_back(x);
  endtask

  // One evaluated clock edge: optional asynchronous reset pulse between edges,
  // then drive the inputs for the coming edge and queue the expected result.
  task automatic step(input logic e, input logic p, input logic [7:0] dh,
                      input logic [7:0] dl, input bit do_rst);
    @(negedge clk);
    rst = 1'b0;
    if (do_rst) begin
      #1 rst = 1'b1;
      #1;
      check("async_rst_a", {ah, al, adt, adrop}, 11'b000_0000_0000);
      check("async_rst_b", {bh, bl, bdt, bdrop}, 11'b110_0000_0000);
      #1 rst = 1'b0;
      model_reset();
    end
    en    = e;
    i_pwm = p;
    dt_hi = dh;
    dt_lo = dl;
    model_edge(e, p, dh, dl);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check("dut_a", {ah, al, adt, adrop}, {mon_e.h, mon_e.l, mon_e.dta, mon_e.drop});
      check("dut_b_pins", {bh, bl, bdt, bdrop}, {~mon_e.h, ~mon_e.l, mon_e.dta, mon_e.drop});
      check("no_overlap", {10'b0, ah & al}, 11'b0);
    end
  end

  initial begin
    logic       rp;
    logic       re;
    logic [7:0] rdh;
    logic [7:0] rdl;
    n_checks = 0;
    n_fail   = 0;
    edge_n   = 0;
    due      = 0;
    model_reset();
    rst   = 1'b0;
    en    = 1'b0;
    i_pwm = 1'b0;
    dt_hi = 8'd0;
    dt_lo = 8'd0;

    // Reset with no clock edge yet
    #1 rst = 1'b1;
    #1;
    check("reset_a", {ah, al, adt, adrop}, 11'b000_0000_0000);
    check("reset_b", {bh, bl, bdt, bdrop}, 11'b110_0000_0000);

    // Dead time 3/2: start low, then up, then down
    repeat (6) step(1'b1, 1'b0, 8'd3, 8'd2, 1'b0);
    repeat (8) step(1'b1, 1'b1, 8'd3, 8'd2, 1'b0);
    repeat (8) step(1'b1, 1'b0, 8'd3, 8'd2, 1'b0);

    // Zero dead time, toggling input
    for (int i = 0; i < 12; i++) step(1'b1, 1'(i % 2), 8'd0, 8'd0, 1'b0);

    // Short pulses swallowed by a 4-cycle high dead time; enough to saturate
    repeat (3) step(1'b1, 1'b0, 8'd4, 8'd1, 1'b0);
    for (int n = 0; n < 300; n++) begin
      repeat (2) step(1'b1, 1'b1, 8'd4, 8'd1, 1'b0);
      repeat (3) step(1'b1, 1'b0, 8'd4, 8'd1, 1'b0);
    end

    // Enable drop while high side is on, then re-enable with dt_hi=5
    repeat (4) step(1'b1, 1'b1, 8'd1, 8'd1, 1'b0);
    step(1'b0, 1'b1, 8'd1, 8'd1, 1'b0);
    repeat (8) step(1'b1, 1'b1, 8'd5, 8'd1, 1'b0);

    // Reset pulse in the middle of a high-side dead time
    repeat (4) step(1'b1, 1'b0, 8'd6, 8'd1, 1'b0);
    repeat (2) step(1'b1, 1'b1, 8'd6, 8'd1, 1'b0);
    step(1'b1, 1'b1, 8'd6, 8'd1, 1'b1);
    repeat (9) step(1'b1, 1'b1, 8'd6, 8'd1, 1'b0);

    // Reset pulse while low side is on
    repeat (5) step(1'b1, 1'b0, 8'd2, 8'd2, 1'b0);
    step(1'b1, 1'b0, 8'd2, 8'd2, 1'b1);
    repeat (5) step(1'b1, 1'b0, 8'd2, 8'd2, 1'b0);

    // Randomized run: held input levels, dt changes mid-window, en drops, resets
    rp  = 1'b0;
    rdh = 8'd2;
    rdl = 8'd3;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(3, 0) == 0) rp = ~rp;
      if ($urandom_range(7, 0) == 0) rdh = 8'($urandom_range(6, 0));
      if ($urandom_range(7, 0) == 0) rdl = 8'($urandom_range(6, 0));
      re = ($urandom_range(31, 0) != 0);
      step(re, rp, rdh, rdl, ($urandom_range(127, 0) == 0));
    end

    @(posedge clk);
    #2;
    check("scoreboard_drained", 11'(sb.size()), 11'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
